// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : dmem_responder                                                    |
// | Brief  : MEM-stage data-memory responder with fixed access latency, stall  |
// |          generation and misaligned/out-of-range error reporting.           |
// |          Optional DMEM_DEBUG_EN adds a combinational RAM debug read port.  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_dout,
  output logic [31:0]           mem_din,
  output logic                  mem_stall,
  output logic                  resp_valid,
  output logic                  mem_err
`ifdef DMEM_DEBUG_EN
  ,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [31:0]           debug_data
`endif
);

  localparam int c_LAT = (LATENCY < 1) ? 1 : ((LATENCY > 15) ? 15 : LATENCY);
  localparam logic [3:0] c_CNT_INIT = 4'(c_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic                  r_wr;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_data;
  logic                  w_req;
  logic                  w_latch;
  logic                  w_done;
  logic                  w_stall;
  logic                  w_addr_err;
  logic [31:0]           r_ram [2**ADDR_WIDTH];

  assign w_req      = mem_ren | mem_wen;
  assign w_addr_err = (mem_addr[1:0] != 2'b00) || ((mem_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  // Stall must drop the moment reset is asserted, even mid-access.
  assign mem_stall  = rst_n & w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_latch = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_stall = 1'b1;
          w_latch = 1'b1;
          w_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (r_cnt == 4'd0) begin
          w_done = 1'b1;
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 4'd0;
      r_wr       <= 1'b0;
      r_err      <= 1'b0;
      r_idx      <= '0;
      r_data     <= 32'd0;
      mem_din    <= 32'd0;
      resp_valid <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      resp_valid <= w_done;
      mem_err    <= w_done & r_err;
      if (w_latch) begin
        r_wr   <= mem_wen;
        r_err  <= w_addr_err;
        r_idx  <= mem_addr[ADDR_WIDTH+1:2];
        r_data <= mem_dout;
        r_cnt  <= c_CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done && !r_wr) begin
        mem_din <= r_err ? 32'd0 : r_ram[r_idx];
      end
    end
  end

  // RAM has no reset; w_done is already forced low by the async state reset.
  always_ff @(posedge clk) begin
    if (w_done && r_wr && !r_err) begin
      r_ram[r_idx] <= r_data;
    end
  end

`ifdef DMEM_DEBUG_EN
  assign debug_data = r_ram[debug_addr];
`endif

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the pipeline's MEM-stage port (mem_ren / mem_wen / mem_addr / mem_dout in, mem_din out).
- Holds a word-addressed RAM behind a fixed, parameterised access latency.
- Asserts mem_stall so the pipeline controller freezes the MEM stage (and everything behind it) until the access completes.
- Flags misaligned and out-of-range accesses on mem_err.

Parameters:
- ADDR_WIDTH, 10: word-index bits; RAM depth is 2^ADDR_WIDTH words, covering byte addresses 0 to 4*2^ADDR_WIDTH-1.
- LATENCY, 2: wait cycles between acceptance and response. Legal range 1..15. Values below 1 are treated as 1.

Ports:
- clk  input  1  main clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_ren  input  1  read request from the MEM stage.
- mem_wen  input  1  write request from the MEM stage.
- mem_addr  input  32  byte address; must be word aligned.
- mem_dout  input  32  write data from the CPU.
- mem_din  output  32  read data to the CPU; valid while resp_valid=1.
- mem_stall  output  1  hold request; the MEM stage must not advance while high.
- resp_valid  output  1  one-cycle pulse in which the access completes.
- mem_err  output  1  error for the responding access; valid with resp_valid.

Behaviour:
- Clock and reset: one clock, clk. rst_n is an asynchronous, active-low reset.
- Reset values:
  - state = IDLE, cnt = 0.
  - mem_din = 0, resp_valid = 0, mem_err = 0.
  - mem_stall = 0 while rst_n is low.
  - RAM contents are not cleared.
- Request: req = mem_ren | mem_wen, sampled only in IDLE.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, req=1:
    - mem_stall=1 (combinational, same cycle).
    - At the edge, latch the operation (write if mem_wen, else read), mem_addr and mem_dout; cnt <= LATENCY-1; go to WAIT.
  - WAIT:
    - mem_stall=1.
    - If cnt!=0: cnt decrements by 1 at the edge.
    - If cnt==0: at the edge, perform the access and go to RESP.
  - RESP:
    - mem_stall=0, resp_valid=1.
    - Go to IDLE at the next edge. The CPU advances on that same edge.
  - IDLE, req=0: no change; mem_stall=0.
- Timing:
  - A request is stalled for exactly LATENCY+1 cycles, followed by 1 response cycle.
  - Back-to-back requests each incur the full sequence. A request seen in IDLE directly after RESP is a new access.
- Access, performed on the WAIT-to-RESP edge:
  - Write: RAM[addr[ADDR_WIDTH+1:2]] <= latched data.
  - Read: mem_din <= RAM[index].
- mem_din holds its last value outside read responses. Writes do not modify mem_din.
- mem_ren and mem_wen both high: treated as a write; mem_din is unchanged; mem_err=0.
- Error conditions: addr[1:0]!=0, or addr[31:ADDR_WIDTH+2] nonzero.
  - No RAM access is performed.
  - mem_din <= 0 for a read.
  - mem_err=1 during RESP.
- mem_err and resp_valid are registered and are 0 in all states other than RESP.
- Request inputs that change during WAIT are ignored; the latched values are used.
- rst_n asserted mid-access: FSM returns to IDLE immediately, and a pending write is discarded (never committed).

Optional Feature:
- Macro: DMEM_DEBUG_EN.
- Defined:
  - Adds input debug_addr[ADDR_WIDTH-1:0] and output debug_data[31:0].
  - debug_data = RAM[debug_addr], combinational.
  - The debug port has no effect on FSM timing or stalls.
  - A word being written reads its new value from the cycle after the committing edge.
- Undefined: neither port exists, and there is no extra read logic.

Test Plan:
1. LATENCY=2. Write 0xDEADBEEF to addr 0x10 (mem_wen=1) → mem_stall high for 3 cycles; resp_valid for 1 cycle, mem_err=0. A following read of 0x10 → after 3 stall cycles, mem_din=0xDEADBEEF with resp_valid=1.
2. Read addr 0x12 (misaligned) → 3 stall cycles, then resp_valid=1, mem_err=1, mem_din=0. RAM[4] is unchanged, as confirmed by a later read.
3. ADDR_WIDTH=10. Write 0x1234 to addr 0x1000 (out of range) → mem_err=1, no write. A read of addr 0x0 afterwards returns its prior value.
4. mem_ren=mem_wen=1, addr 0x8, data 0x55 → treated as a write, mem_din unchanged, mem_err=0. A subsequent read of 0x8 returns 0x55.
5. Start a write of 0xA5A5A5A5 to 0x20; pull rst_n low in the first WAIT cycle → mem_stall=0 and state IDLE immediately. A read of 0x20 after reset returns the old contents.
6. LATENCY=1. Issue back-to-back reads of 0x0 and 0x4 → each read has a stall/stall/response pattern, giving 6 cycles total and two resp_valid pulses with the correct data.
